// File: rtl/seg_scan_driver.sv
// seg_scan_driver: two-group multiplexed 7-segment scan driver.
// Frame-latched data, dead-time blanking, free-running blink.
package project_pkg;

   typedef logic [4:0] code_t;

   localparam code_t CHAR_0   = 5'd0;
   localparam code_t CHAR_1   = 5'd1;
   localparam code_t CHAR_2   = 5'd2;
   localparam code_t CHAR_3   = 5'd3;
   localparam code_t CHAR_4   = 5'd4;
   localparam code_t CHAR_5   = 5'd5;
   localparam code_t CHAR_6   = 5'd6;
   localparam code_t CHAR_7   = 5'd7;
   localparam code_t CHAR_8   = 5'd8;
   localparam code_t CHAR_9   = 5'd9;
   localparam code_t CHAR_A   = 5'd10;
   localparam code_t CHAR_B   = 5'd11;
   localparam code_t CHAR_C   = 5'd12;
   localparam code_t CHAR_D   = 5'd13;
   localparam code_t CHAR_E   = 5'd14;
   localparam code_t CHAR_F   = 5'd15;
   localparam code_t CHAR_H   = 5'd16;
   localparam code_t CHAR_L   = 5'd17;
   localparam code_t CHAR_P   = 5'd18;
   localparam code_t CHAR_BLK = 5'd31;

   // {dp,g,f,e,d,c,b,a}, active-high; unknown codes go dark
   function automatic logic [7:0] code_to_seg(input code_t c);
      logic [7:0] s;
      case (c)
         CHAR_0:  s = 8'h3F;
         CHAR_1:  s = 8'h06;
         CHAR_2:  s = 8'h5B;
         CHAR_3:  s = 8'h4F;
         CHAR_4:  s = 8'h66;
         CHAR_5:  s = 8'h6D;
         CHAR_6:  s = 8'h7D;
         CHAR_7:  s = 8'h07;
         CHAR_8:  s = 8'h7F;
         CHAR_9:  s = 8'h6F;
         CHAR_A:  s = 8'h77;
         CHAR_B:  s = 8'h7C;
         CHAR_C:  s = 8'h39;
         CHAR_D:  s = 8'h5E;
         CHAR_E:  s = 8'h79;
         CHAR_F:  s = 8'h71;
         CHAR_H:  s = 8'h76;
         CHAR_L:  s = 8'h38;
         CHAR_P:  s = 8'h73;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

endpackage

module seg_scan_driver
   import project_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int DEAD_CYC  = 2_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            disp_en,
   input  code_t [7:0]     seg_data,
   input  logic  [7:0]     seg_blink,
   output logic  [7:0]     seg_an,
   output logic  [7:0]     seg_l,
   output logic  [7:0]     seg_r,
   output logic            frame_tick
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [PW:0]   DEAD    = (PW + 1)'(DEAD_CYC);

   logic [PW-1:0] pre_q, pre_d;
   logic [1:0]    slot_q, slot_d;
   logic [BW-1:0] blk_q, blk_d;
   logic          phase_q, phase_d;
   code_t [7:0]   sh_data_q, sh_data_d;
   logic [7:0]    sh_blink_q, sh_blink_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    l_q, l_d;
   logic [7:0]    r_q, r_d;
   logic          tick_q, tick_d;

   logic          frame_start;
   logic          pre_term;

   // Scan/blink counters and frame-boundary shadow capture
   always_comb begin
      pre_term    = (pre_q == PRE_MAX);
      frame_start = (slot_q == 2'd0) && (pre_q == '0);
      pre_d       = pre_term ? '0 : pre_q + 1'b1;
      slot_d      = pre_term ? slot_q + 2'd1 : slot_q;
      blk_d       = (blk_q == BLK_MAX) ? '0 : blk_q + 1'b1;
      phase_d     = (blk_q == BLK_MAX) ? ~phase_q : phase_q;
      sh_data_d   = frame_start ? seg_data : sh_data_q;
      sh_blink_d  = frame_start ? seg_blink : sh_blink_q;
      tick_d      = (slot_d == 2'd0) && (pre_d == '0);
   end

   logic [2:0] idx_l, idx_r;
   logic       blank, sup_l, sup_r;

   // Pin values for the current slot; registered below
   always_comb begin
      idx_l = {1'b1, slot_q};
      idx_r = {1'b0, slot_q};
      blank = !disp_en || ({1'b0, pre_q} < DEAD);
      sup_l = sh_blink_d[idx_l] & phase_q;
      sup_r = sh_blink_d[idx_r] & phase_q;
      an_d  = '0;
      l_d   = '0;
      r_d   = '0;
      if (!blank) begin
         if (!sup_l) begin
            an_d[idx_l] = 1'b1;
            l_d         = code_to_seg(sh_data_d[idx_l]);
         end
         if (!sup_r) begin
            an_d[idx_r] = 1'b1;
            r_d         = code_to_seg(sh_data_d[idx_r]);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         slot_q     <= '0;
         blk_q      <= '0;
         phase_q    <= 1'b0;
         sh_data_q  <= {8{CHAR_BLK}};
         sh_blink_q <= '0;
         an_q       <= '0;
         l_q        <= '0;
         r_q        <= '0;
         tick_q     <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         slot_q     <= slot_d;
         blk_q      <= blk_d;
         phase_q    <= phase_d;
         sh_data_q  <= sh_data_d;
         sh_blink_q <= sh_blink_d;
         an_q       <= an_d;
         l_q        <= l_d;
         r_q        <= r_d;
         tick_q     <= tick_d;
      end
   end

   assign seg_an     = an_q;
   assign seg_l      = l_q;
   assign seg_r      = r_q;
   assign frame_tick = tick_q;

endmodule
